// File: rtl/prf_operand_read.sv
// Operand-read stage: drives PRF read addresses, bypasses same-cycle writebacks, registers operands per lane.
// Latency: 1 cycle from issue accept to opr_* outputs; lanes are independent; P0 always reads as zero.
// Backpressure: a lane accepts when its output stage is empty or draining this cycle; flush_i blocks all accepts.
module prf_operand_read #(
    parameter int REG_SIZE       = 64,
    parameter int REG_SIZE_WIDTH = 6,
    parameter int PAYLOAD_WIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      flush_i,

    input  logic                      issue_valid_first_i,
    output logic                      issue_ready_first_o,
    input  logic [REG_SIZE_WIDTH-1:0] issue_prs1_first_i,
    input  logic [REG_SIZE_WIDTH-1:0] issue_prs2_first_i,
    input  logic [PAYLOAD_WIDTH-1:0]  issue_payload_first_i,
    output logic [REG_SIZE_WIDTH-1:0] prs1_address_first_o,
    output logic [REG_SIZE_WIDTH-1:0] prs2_address_first_o,
    input  logic [63:0]               prs1_data_first_i,
    input  logic [63:0]               prs2_data_first_i,

    input  logic                      issue_valid_second_i,
    output logic                      issue_ready_second_o,
    input  logic [REG_SIZE_WIDTH-1:0] issue_prs1_second_i,
    input  logic [REG_SIZE_WIDTH-1:0] issue_prs2_second_i,
    input  logic [PAYLOAD_WIDTH-1:0]  issue_payload_second_i,
    output logic [REG_SIZE_WIDTH-1:0] prs1_address_second_o,
    output logic [REG_SIZE_WIDTH-1:0] prs2_address_second_o,
    input  logic [63:0]               prs1_data_second_i,
    input  logic [63:0]               prs2_data_second_i,

    input  logic [REG_SIZE_WIDTH-1:0] alu1_wrb_address_i,
    input  logic [63:0]               alu1_wrb_data_i,
    input  logic                      alu1_rcu_resp_valid_i,
    input  logic [REG_SIZE_WIDTH-1:0] alu2_wrb_address_i,
    input  logic [63:0]               alu2_wrb_data_i,
    input  logic                      alu2_rcu_resp_valid_i,
    input  logic [REG_SIZE_WIDTH-1:0] lsu_wrb_address_i,
    input  logic [63:0]               lsu_wrb_data_i,
    input  logic                      lsu_rcu_resp_valid_i,
    input  logic [REG_SIZE_WIDTH-1:0] md_wrb_address_i,
    input  logic [63:0]               md_wrb_data_i,
    input  logic                      md_rcu_resp_valid_i,

    output logic                      opr_valid_first_o,
    input  logic                      opr_ready_first_i,
    output logic [63:0]               opr_rs1_first_o,
    output logic [63:0]               opr_rs2_first_o,
    output logic [PAYLOAD_WIDTH-1:0]  opr_payload_first_o,

    output logic                      opr_valid_second_o,
    input  logic                      opr_ready_second_i,
    output logic [63:0]               opr_rs1_second_o,
    output logic [63:0]               opr_rs2_second_o,
    output logic [PAYLOAD_WIDTH-1:0]  opr_payload_second_o
);

    localparam int RSW = REG_SIZE_WIDTH;
    localparam int PW  = PAYLOAD_WIDTH;

    if (REG_SIZE > (1 << REG_SIZE_WIDTH)) begin : g_size_check
        $error("REG_SIZE does not fit in REG_SIZE_WIDTH address bits");
    end

    typedef struct packed {
        logic [63:0]   rs1;
        logic [63:0]   rs2;
        logic [PW-1:0] payload;
    } opr_t;

    // Writeback ports ordered lowest to highest priority so the last match wins.
    logic [3:0]            wrb_vld;
    logic [3:0][RSW-1:0]   wrb_addr;
    logic [3:0][63:0]      wrb_dat;

    assign wrb_vld  = {md_rcu_resp_valid_i, lsu_rcu_resp_valid_i,
                       alu2_rcu_resp_valid_i, alu1_rcu_resp_valid_i};
    assign wrb_addr = {md_wrb_address_i, lsu_wrb_address_i,
                       alu2_wrb_address_i, alu1_wrb_address_i};
    assign wrb_dat  = {md_wrb_data_i, lsu_wrb_data_i,
                       alu2_wrb_data_i, alu1_wrb_data_i};

    function automatic logic [63:0] resolve(
        input logic [RSW-1:0]      addr,
        input logic [63:0]         file_dat,
        input logic [3:0]          vld,
        input logic [3:0][RSW-1:0] waddr,
        input logic [3:0][63:0]    wdat
    );
        logic [63:0] res;
        res = file_dat;
        for (int w = 0; w < 4; w++) begin
            if (vld[w] && (waddr[w] == addr)) begin
                res = wdat[w];
            end
        end
        if (addr == '0) begin
            res = '0;
        end
        return res;
    endfunction

    logic [1:0]            issue_vld;
    logic [1:0]            issue_rdy;
    logic [1:0]            opr_rdy;
    logic [1:0]            accept;
    logic [1:0][RSW-1:0]   rs1_addr;
    logic [1:0][RSW-1:0]   rs2_addr;
    logic [1:0][63:0]      rs1_file;
    logic [1:0][63:0]      rs2_file;
    logic [1:0][PW-1:0]    issue_pay;
    logic [1:0]            stage_vld_q;
    opr_t [1:0]            stage_q;
    opr_t [1:0]            stage_d;

    assign issue_vld = {issue_valid_second_i, issue_valid_first_i};
    assign opr_rdy   = {opr_ready_second_i, opr_ready_first_i};
    assign rs1_addr  = {issue_prs1_second_i, issue_prs1_first_i};
    assign rs2_addr  = {issue_prs2_second_i, issue_prs2_first_i};
    assign rs1_file  = {prs1_data_second_i, prs1_data_first_i};
    assign rs2_file  = {prs2_data_second_i, prs2_data_first_i};
    assign issue_pay = {issue_payload_second_i, issue_payload_first_i};

    for (genvar g = 0; g < 2; g++) begin : g_lane
        assign issue_rdy[g] = !flush_i && (!stage_vld_q[g] || opr_rdy[g]);
        assign accept[g]    = issue_vld[g] && issue_rdy[g];

        always_comb begin
            stage_d[g]         = '0;
            stage_d[g].rs1     = resolve(rs1_addr[g], rs1_file[g], wrb_vld, wrb_addr, wrb_dat);
            stage_d[g].rs2     = resolve(rs2_addr[g], rs2_file[g], wrb_vld, wrb_addr, wrb_dat);
            stage_d[g].payload = issue_pay[g];
        end

        // Held entries keep their operands frozen; they are not re-bypassed.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                stage_vld_q[g] <= 1'b0;
                stage_q[g]     <= '0;
            end else if (flush_i) begin
                stage_vld_q[g] <= 1'b0;
            end else if (accept[g]) begin
                stage_vld_q[g] <= 1'b1;
                stage_q[g]     <= stage_d[g];
            end else if (opr_rdy[g]) begin
                stage_vld_q[g] <= 1'b0;
            end
        end
    end

    assign issue_ready_first_o   = issue_rdy[0];
    assign issue_ready_second_o  = issue_rdy[1];
    assign prs1_address_first_o  = issue_prs1_first_i;
    assign prs2_address_first_o  = issue_prs2_first_i;
    assign prs1_address_second_o = issue_prs1_second_i;
    assign prs2_address_second_o = issue_prs2_second_i;

    assign opr_valid_first_o     = stage_vld_q[0];
    assign opr_rs1_first_o       = stage_q[0].rs1;
    assign opr_rs2_first_o       = stage_q[0].rs2;
    assign opr_payload_first_o   = stage_q[0].payload;
    assign opr_valid_second_o    = stage_vld_q[1];
    assign opr_rs1_second_o      = stage_q[1].rs1;
    assign opr_rs2_second_o      = stage_q[1].rs2;
    assign opr_payload_second_o  = stage_q[1].payload;

endmodule
